// File: rtl/dct_mac_sequencer.sv
// Control sequencer for one DCT multiply-accumulate unit: steps coefficient index per sample,
// drives accumulator clear/enable and result-register capture, and hands results downstream.
module dct_mac_sequencer #(
    parameter int unsigned TAPS    = 8,
    parameter int unsigned MAC_LAT = 2,
    parameter int unsigned CW      = $clog2(TAPS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          smp_valid,
    output logic          smp_ready,
    output logic          mac_en,
    output logic          mac_clr,
    output logic [CW-1:0] coef_idx,
    output logic          res_en,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          busy
);

    typedef enum logic [1:0] {
        SlotEmpty,
        SlotDrain,
        SlotFull
    } slot_e;

    slot_e                slot_q, slot_d;
    logic [CW-1:0]        tap_q, tap_d;
    logic [MAC_LAT-1:0]   lat_q, lat_d;
    logic                 last_tap;
    logic                 acc;
    logic                 last_acc;

    assign last_tap = (tap_q == CW'(TAPS - 1));
    assign res_en   = lat_q[MAC_LAT-1];

    // Only the final tap is ever stalled; earlier taps of the next vector overlap the drain.
    always_comb begin
        smp_ready = 1'b1;
        if (last_tap) begin
            smp_ready = (slot_q == SlotEmpty) || ((slot_q == SlotFull) && out_ready);
        end
    end

    // Gating with rst_n keeps mac_en low while reset is held with smp_valid high.
    assign acc       = smp_valid & smp_ready & rst_n;
    assign last_acc  = acc & last_tap;
    assign mac_en    = acc;
    assign mac_clr   = acc & (tap_q == '0);
    assign coef_idx  = tap_q;
    assign out_valid = (slot_q == SlotFull);
    assign busy      = (tap_q != '0) || (slot_q != SlotEmpty);

    always_comb begin
        tap_d = tap_q;
        if (acc) begin
            tap_d = last_tap ? '0 : tap_q + CW'(1);
        end
    end

    always_comb begin
        lat_d    = lat_q << 1;
        lat_d[0] = last_acc;
    end

    always_comb begin
        slot_d = slot_q;
        unique case (slot_q)
            SlotEmpty: if (last_acc) slot_d = SlotDrain;
            SlotDrain: if (res_en) slot_d = SlotFull;
            SlotFull:  if (out_ready) slot_d = last_acc ? SlotDrain : SlotEmpty;
            default:   slot_d = SlotEmpty;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q <= SlotEmpty;
            tap_q  <= '0;
            lat_q  <= '0;
        end else begin
            slot_q <= slot_d;
            tap_q  <= tap_d;
            lat_q  <= lat_d;
        end
    end

endmodule

// File: tb/tb_dct_mac_sequencer.sv
// Randomized self-checking bench for dct_mac_sequencer against a cycle-count based
// reference model (sample count, scheduled result time, full flag).
module tb_dct_mac_sequencer;

    localparam int unsigned TAPS    = 8;
    localparam int unsigned MAC_LAT = 2;
    localparam int unsigned CW      = $clog2(TAPS);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          smp_valid = 1'b0;
    logic          smp_ready;
    logic          mac_en;
    logic          mac_clr;
    logic [CW-1:0] coef_idx;
    logic          res_en;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          busy;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int m_cnt    = 0;
    int m_res_at = -1;
    bit m_full   = 1'b0;
    int m_cyc    = 0;

    dct_mac_sequencer #(
        .TAPS   (TAPS),
        .MAC_LAT(MAC_LAT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .smp_valid(smp_valid),
        .smp_ready(smp_ready),
        .mac_en   (mac_en),
        .mac_clr  (mac_clr),
        .coef_idx (coef_idx),
        .res_en   (res_en),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, m_cyc, got, exp);
        end
    endtask

    // One clock: drive at negedge, check 1ns later, advance model, wait for posedge.
    task automatic cycle(input bit rst, input bit v, input bit r);
        bit last, ready, acc, e_res;
        @(negedge clk);
        rst_n     = ~rst;
        smp_valid = v;
        out_ready = r;
        #1;
        if (rst) begin
            m_cnt = 0; m_res_at = -1; m_full = 1'b0;
            check("rst_ready", 32'(smp_ready), 32'd1);
            check("rst_mac_en", 32'(mac_en), 32'd0);
            check("rst_mac_clr", 32'(mac_clr), 32'd0);
            check("rst_coef", 32'(coef_idx), 32'd0);
            check("rst_res_en", 32'(res_en), 32'd0);
            check("rst_out_valid", 32'(out_valid), 32'd0);
            check("rst_busy", 32'(busy), 32'd0);
        end else begin
            last  = (m_cnt == TAPS - 1);
            ready = !last || (m_res_at < 0 && !m_full) || (m_full && r);
            acc   = v && ready;
            e_res = (m_cyc == m_res_at);
            check("smp_ready", 32'(smp_ready), 32'(ready));
            check("mac_en", 32'(mac_en), 32'(acc));
            check("mac_clr", 32'(mac_clr), 32'(acc && m_cnt == 0));
            check("coef_idx", 32'(coef_idx), 32'(m_cnt));
            check("res_en", 32'(res_en), 32'(e_res));
            check("out_valid", 32'(out_valid), 32'(m_full));
            check("busy", 32'(busy), 32'(m_cnt != 0 || m_res_at >= 0 || m_full));
            if (m_full && r) m_full = 1'b0;
            if (e_res) begin
                m_full   = 1'b1;
                m_res_at = -1;
            end
            if (acc && last) m_res_at = m_cyc + MAC_LAT;
            if (acc) m_cnt = (m_cnt + 1) % TAPS;
        end
        m_cyc++;
        @(posedge clk);
    endtask

    initial begin
        int pv, pr;
        // Reset held with smp_valid high
        repeat (3) cycle(1'b1, 1'b1, 1'b0);
        // Single vector, then idle
        repeat (8) cycle(1'b0, 1'b1, 1'b1);
        repeat (5) cycle(1'b0, 1'b0, 1'b1);
        // Gapped input at taps 3 and 4
        for (int i = 0; i < 10; i++) cycle(1'b0, !(i == 3 || i == 4), 1'b1);
        repeat (5) cycle(1'b0, 1'b0, 1'b1);
        // Two back-to-back vectors under backpressure, release late
        for (int i = 0; i < 26; i++) cycle(1'b0, i < 21, i >= 20);
        // Reset mid-drain, then a fresh vector
        repeat (8) cycle(1'b0, 1'b1, 1'b1);
        cycle(1'b1, 1'b1, 1'b1);
        repeat (12) cycle(1'b0, 1'b1, 1'b1);
        repeat (4) cycle(1'b0, 1'b0, 1'b1);
        // Continuous streaming
        repeat (48) cycle(1'b0, 1'b1, 1'b1);
        // Randomized traffic with varying biases and occasional resets
        for (int blk = 0; blk < 30; blk++) begin
            pv = $urandom_range(30, 100);
            pr = $urandom_range(5, 100);
            for (int i = 0; i < 80; i++) begin
                cycle($urandom_range(0, 399) == 0, $urandom_range(1, 100) <= pv,
                      $urandom_range(1, 100) <= pr);
            end
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dct_mac_sequencer.md
Name: dct_mac_sequencer

Overview:
- Control sequencer for one multiply-accumulate unit inside a DCT unit of the fdct_zigzag path.
- Accepts a stream of input samples and steps the coefficient index per sample.
- Drives the clear and enable inputs of the MAC accumulator, and drives the capture enable of the MAC result register (a DFFE).
- Hands each completed dot product downstream with a valid/ready handshake and applies backpressure so an unconsumed result is never overwritten.

Parameters:
- TAPS, 8: samples per dot product; must be >= 2.
- MAC_LAT, 2: cycles from an accepted sample to its product being summed into the accumulator; must be >= 1.
- CW, $clog2(TAPS): width of coef_idx.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- smp_valid  in  1  upstream sample present.
- smp_ready  out  1  sequencer can accept a sample.
- mac_en  out  1  MAC consumes the current sample/coefficient pair.
- mac_clr  out  1  with mac_en: accumulator loads the product instead of adding it.
- coef_idx  out  CW  coefficient ROM index for the current sample.
- res_en  out  1  one-cycle capture enable for the MAC result register.
- out_valid  out  1  result register holds an unconsumed dot product.
- out_ready  in  1  downstream accepts the result.
- busy  out  1  tap counter non-zero, or result slot not EMPTY.

Behaviour:
- Reset (asynchronous, rst_n low):
  - Tap counter = 0, slot = EMPTY, latency shift register cleared.
  - smp_ready = 1; mac_en = mac_clr = res_en = out_valid = busy = 0; coef_idx = 0.
- Accept: acc = smp_valid & smp_ready.
  - mac_en = acc, combinational.
  - mac_clr = acc & (tap == 0).
  - coef_idx = tap, registered counter value.
- Tap counter:
  - On acc, increments; wraps from TAPS-1 to 0.
  - Holds when acc = 0. Gaps in smp_valid are allowed at any tap.
- Drain pipeline:
  - When acc occurs with tap == TAPS-1 (the last tap) in cycle t, a token enters a MAC_LAT-deep shift register.
  - res_en pulses for exactly one cycle at t+MAC_LAT.
- Result slot FSM:
  - EMPTY -> DRAIN on last-tap acceptance.
  - DRAIN -> FULL in the cycle res_en is high.
  - FULL -> EMPTY on out_valid & out_ready.
  - out_valid = 1 exactly while the slot is FULL, i.e. registered, starting at t+MAC_LAT+1.
- Backpressure:
  - smp_ready = 0 only when tap == TAPS-1 and the slot is DRAIN, or FULL without out_ready.
  - A FULL slot with out_ready high in the same cycle allows the last tap to be accepted (EMPTY -> DRAIN and FULL -> EMPTY merge to DRAIN).
  - Taps 0..TAPS-2 of the next vector are always accepted, including during DRAIN/FULL. Their products reach the accumulator only after res_en.
- out_valid, once high, holds until the handshake; the result register is never re-enabled while the slot is FULL.
- Reset mid-operation discards the partial vector and any in-flight result; no res_en or out_valid follows reset.
- No combinational path from out_ready to out_valid. smp_ready depends combinationally on out_ready only in the final-tap case.

Test Plan:
- Reset: hold rst_n low for 3 cycles with smp_valid=1 -> all outputs at reset values, smp_ready=1, no mac_en.
- Single vector (TAPS=8, MAC_LAT=2), smp_valid high cycles 0..7, out_ready=1:
  - mac_en cycles 0..7; mac_clr only at cycle 0; coef_idx 0,1,..,7.
  - res_en at cycle 9 only; out_valid at cycle 10 only.
- Gapped input: smp_valid low on cycles 3 and 4 of the same stream -> coef_idx holds at 3; last acceptance at cycle 9; res_en at 11; out_valid at 12.
- Backpressure: two back-to-back vectors with out_ready=0:
  - Second vector's taps 0..6 accepted; smp_ready=0 at tap 7 while out_valid=1.
  - Raise out_ready at cycle 20 -> tap 7 accepted that same cycle; second res_en at cycle 22; out_valid high again at cycle 23.
- Reset mid-drain: assert rst_n low at cycle 8 of the single-vector case -> no res_en at cycle 9, out_valid stays 0, the next vector starts with coef_idx=0 and mac_clr=1.
- Continuous streaming with out_ready=1 -> one result every 8 cycles; smp_ready never drops; res_en spacing exactly 8.
